data_mem_unit: RTL

- Data-memory stage of the single-cycle core; sits directly downstream of the ALU.
- Takes the ALU result as the byte address, rs2 as store data, plus the DmWr/DmCtrl controls from the control unit.
- Returns load data to the register-file write-back mux (RuDataWrsrc = 2'b01).
- Contains a word-organised RAM and a small memory-mapped block: free-running timer, compare register, sticky match flag, GPIO output register.

---
 rtl/data_mem_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/data_mem_unit.sv
// Data-memory stage: word RAM with byte/half/word lanes plus MMIO timer, compare, match flag and GPIO.
// Combinational reads, clocked writes; DM_MISALIGN_TRAP_EN suppresses misaligned accesses instead of force-aligning.
module data_mem_unit #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
   parameter int          GPIO_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       address,
   input  logic [31:0]       data_wr,
   input  logic              dm_wr,
   input  logic [2:0]        dm_ctrl,
   output logic [31:0]       data_rd,
   output logic              misaligned,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              tmr_match
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]       mem [DEPTH_WORDS];
   logic [31:0]       timer_q;
   logic [31:0]       tmrcmp_q;
   logic [GPIO_W-1:0] gpio_q;
   logic              match_q;

   logic [AW-1:0] ram_idx;
   logic          is_mmio;
   logic [1:0]    reg_sel;
   logic          ctrl_ok;
   logic          size_b;
   logic          size_h;
   logic          size_w;
   logic          access_ok;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [3:0]    byte_en;
   logic [31:0]   wr_lanes;
   logic          wr_en;
   logic          ram_we;
   logic          mmio_we;

   assign ram_idx = address[AW+1:2];
   assign is_mmio = (address[31:4] == MMIO_BASE[31:4]);
   assign reg_sel = address[3:2];

   assign ctrl_ok = (dm_ctrl == 3'b000) || (dm_ctrl == 3'b001) || (dm_ctrl == 3'b010) ||
                    (dm_ctrl == 3'b100) || (dm_ctrl == 3'b101);
   assign size_b  = ctrl_ok && (dm_ctrl[1:0] == 2'b00);
   assign size_h  = ctrl_ok && (dm_ctrl[1:0] == 2'b01);
   assign size_w  = (dm_ctrl == 3'b010);

   assign misaligned = (size_h && address[0]) || (size_w && (address[1:0] != 2'b00));

`ifdef DM_MISALIGN_TRAP_EN
   assign access_ok = ctrl_ok && !misaligned;
`else
   assign access_ok = ctrl_ok;
`endif

   always_comb begin
      rd_word = mem[ram_idx];
      if (is_mmio) begin
         case (reg_sel)
            2'd0:    rd_word = timer_q;
            2'd1:    rd_word = tmrcmp_q;
            2'd2:    rd_word = 32'(gpio_q);
            default: rd_word = {31'b0, match_q};
         endcase
      end
   end

   // Halfword lane uses address[1] only, so a force-aligned H never straddles words
   always_comb begin
      data_rd  = 32'b0;
      rd_shift = 32'b0;
      if (access_ok) begin
         if (size_b) begin
            rd_shift = rd_word >> {address[1:0], 3'b000};
            data_rd  = dm_ctrl[2] ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
         end else if (size_h) begin
            rd_shift = rd_word >> {address[1], 4'b0000};
            data_rd  = dm_ctrl[2] ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
         end else begin
            data_rd  = rd_word;
         end
      end
   end

   always_comb begin
      byte_en  = 4'b0000;
      wr_lanes = data_wr;
      if (size_b) begin
         byte_en[address[1:0]] = 1'b1;
         wr_lanes = {4{data_wr[7:0]}};
      end else if (size_h) begin
         byte_en  = address[1] ? 4'b1100 : 4'b0011;
         wr_lanes = {2{data_wr[15:0]}};
      end else if (size_w) begin
         byte_en  = 4'b1111;
      end
   end

   assign wr_en   = dm_wr && access_ok;
   assign ram_we  = wr_en && !is_mmio;
   assign mmio_we = wr_en && is_mmio && size_w;

   // RAM has no reset; the rst gate only drops a store landing during reset
   always_ff @(posedge clk) begin
      if (ram_we && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[ram_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q  <= 32'b0;
         tmrcmp_q <= 32'hFFFF_FFFF;
         gpio_q   <= '0;
         match_q  <= 1'b0;
      end else begin
         if (mmio_we && (reg_sel == 2'd0)) timer_q <= data_wr;
         else                              timer_q <= timer_q + 32'd1;
         if (mmio_we && (reg_sel == 2'd1)) tmrcmp_q <= data_wr;
         if (mmio_we && (reg_sel == 2'd2)) gpio_q   <= data_wr[GPIO_W-1:0];
         // Set has priority over a same-cycle software clear
         if (timer_q == tmrcmp_q)                              match_q <= 1'b1;
         else if (mmio_we && (reg_sel == 2'd3) && data_wr[0]) match_q <= 1'b0;
      end
   end

   assign gpio_out  = gpio_q;
   assign tmr_match = match_q;
endmodule
